// File: rtl/qei_pkg.sv
// Shared state type, {A, B, Z} bit positions and phase decode used by the QEI
// encoder emulator (and the bit order matches the QEI decoder conduit).
package qei_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        FINISH = 2'd2
    } emu_state_e;

    localparam int ENC_A = 2;
    localparam int ENC_B = 1;
    localparam int ENC_Z = 0;

    // Gray phase walk: increments lead with A, decrements lead with B.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/qei_step_timer.sv
// Edge-period down-counter: loads the period on start and on every expiry,
// emitting a one-cycle tick each time it expires.
module qei_step_timer
    import qei_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] reload_q;
    logic [DIV_W-1:0] reload_d;

    // A zero period is promoted to one so the counter never stalls.
    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        if (start) begin
            reload_d = (period == '0) ? DIV_W'(1) : period;
            cnt_d    = reload_d;
        end else if (stop) begin
            cnt_d = '0;
        end else if (cnt_q == DIV_W'(1)) begin
            cnt_d = reload_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

    assign tick = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/qei_encoder_emulator.sv
// Quadrature A/B/Z generator that walks an emulated shaft to a commanded target.
// Define QEI_EMU_Z_EN to compile in index (Z) generation; otherwise Z is tied low.
module qei_encoder_emulator
    import qei_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DIV_W = 16,
    parameter int CPR   = 2048
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_target,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic [2:0]       encabz,
    output logic [CNT_W-1:0] position,
    output logic             busy,
    output logic             done
);

    localparam logic signed [CNT_W-1:0] ONE = CNT_W'(1);

    if (CPR < 4 || (CPR & (CPR - 1)) != 0) begin : g_bad_cpr
        $error("qei_encoder_emulator: CPR must be a power of two >= 4");
    end

    emu_state_e              state_q;
    emu_state_e              state_d;
    logic signed [CNT_W-1:0] position_q;
    logic signed [CNT_W-1:0] position_d;
    logic signed [CNT_W-1:0] target_q;
    logic signed [CNT_W-1:0] target_d;
    logic [2:0]              encabz_q;
    logic [2:0]              encabz_d;
    logic                    accept;
    logic                    tick;
    logic                    timer_stop;
    logic                    z_next;

    assign accept     = cmd_valid && (state_q == IDLE);
    assign timer_stop = (state_d != MOVE);

    qei_step_timer #(
        .DIV_W (DIV_W)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (accept),
        .stop   (timer_stop),
        .period (cmd_period),
        .tick   (tick)
    );

    // The final step and the move to FINISH share an edge, so done follows it directly.
    always_comb begin
        state_d    = state_q;
        position_d = position_q;
        target_d   = target_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = cmd_target;
                    state_d  = MOVE;
                end
            end
            MOVE: begin
                if (abort || (position_q == target_q)) begin
                    state_d = FINISH;
                end else if (tick) begin
                    position_d = (target_q > position_q) ? position_q + ONE
                                                         : position_q - ONE;
                    if (position_d == target_q) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef QEI_EMU_Z_EN
    localparam int            Z_BITS     = $clog2(CPR);
    localparam logic [2:0]    ENCABZ_RST = 3'b001;
    assign z_next = (position_d[Z_BITS-1:0] == '0);
`else
    localparam logic [2:0]    ENCABZ_RST = 3'b000;
    assign z_next = 1'b0;
`endif

    // Decoding from the next position keeps encabz aligned with position.
    always_comb begin
        encabz_d = '0;
        {encabz_d[ENC_A], encabz_d[ENC_B]} = phase_to_ab(position_d[1:0]);
        encabz_d[ENC_Z] = z_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            position_q <= '0;
            target_q   <= '0;
            encabz_q   <= ENCABZ_RST;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            target_q   <= target_d;
            encabz_q   <= encabz_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == MOVE);
    assign done      = (state_q == FINISH);
    assign position  = position_q;
    assign encabz    = encabz_q;

endmodule

// File: tb/tb_qei_encoder_emulator.sv
// Directed, table-driven bench for qei_encoder_emulator; Z expectations follow QEI_EMU_Z_EN.
module tb_qei_encoder_emulator;

    localparam int CNT_W = 32;
    localparam int DIV_W = 16;
    localparam int CPR   = 2048;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             abort;
    logic [CNT_W-1:0] cmd_target;
    logic [DIV_W-1:0] cmd_period;
    logic             cmd_ready;
    logic             busy;
    logic             done;
    logic [2:0]       encabz;
    logic [CNT_W-1:0] position;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int start;
        int target;
        int period;
        int steps;
    } move_vec_t;

    move_vec_t vecs[6];

    always #10 clk = ~clk;

    qei_encoder_emulator #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W),
        .CPR   (CPR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_period (cmd_period),
        .abort      (abort),
        .encabz     (encabz),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    // Reference {A, B, Z} for a shaft position, written out from the phase table.
    function automatic logic [2:0] exp_abz(input int pos);
        logic [1:0] ph;
        logic [2:0] v;
        ph = pos[1:0];
        case (ph)
            2'd0:    v = 3'b000;
            2'd1:    v = 3'b100;
            2'd2:    v = 3'b110;
            default: v = 3'b010;
        endcase
`ifdef QEI_EMU_Z_EN
        if ((pos % CPR) == 0) v[0] = 1'b1;
`endif
        return v;
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Offers one command; returns #1 after the accepting edge.
    task automatic applyStimulus(input int target, input int period);
        checkOutput("cmd_ready before command", 32'(cmd_ready), 32'd1);
        cmd_target = target;
        cmd_period = DIV_W'(period);
        cmd_valid  = 1'b1;
        step_clk();
        cmd_valid  = 1'b0;
    endtask

    // Checks every cycle of a move, starting #1 after the accepting edge (j=0).
    task automatic checkMove(input int start, input int target, input int period,
                             input int steps, input string tag);
        int p;
        int dir;
        int jend;
        int k;
        int exp_pos;
        p    = (period == 0) ? 1 : period;
        dir  = (target > start) ? 1 : ((target < start) ? -1 : 0);
        jend = (steps == 0) ? 1 : steps * p;
        for (int j = 0; j <= jend + 1; j++) begin
            k = j / p;
            if (k > steps) k = steps;
            exp_pos = start + dir * k;
            checkOutput($sformatf("%s position j=%0d", tag, j), position, exp_pos);
            checkOutput($sformatf("%s encabz j=%0d", tag, j), 32'(encabz), 32'(exp_abz(exp_pos)));
            checkOutput($sformatf("%s busy j=%0d", tag, j), 32'(busy), 32'(j < jend));
            checkOutput($sformatf("%s done j=%0d", tag, j), 32'(done), 32'(j == jend));
            checkOutput($sformatf("%s cmd_ready j=%0d", tag, j), 32'(cmd_ready), 32'(j > jend));
            if (j <= jend) step_clk();
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        cmd_target = '0;
        cmd_period = '0;

        // start, target, period, hand-counted steps
        vecs[0] = '{0, 8, 4, 8};
        vecs[1] = '{8, -3, 1, 11};
        vecs[2] = '{-3, -3, 5, 0};
        vecs[3] = '{-3, 0, 0, 3};
        vecs[4] = '{0, 2, 1, 2};
        vecs[5] = '{2, 5, 3, 3};

        step_clk();
        step_clk();
        checkOutput("reset position", position, 32'd0);
        checkOutput("reset encabz", 32'(encabz), 32'(exp_abz(0)));
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        step_clk();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].target, vecs[i].period);
            checkMove(vecs[i].start, vecs[i].target, vecs[i].period, vecs[i].steps,
                      $sformatf("vec%0d", i));
        end

        // Abort while idle must be ignored.
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        checkOutput("idle abort cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("idle abort done", 32'(done), 32'd0);
        checkOutput("idle abort busy", 32'(busy), 32'd0);
        checkOutput("idle abort position", position, 32'd5);

        // Abort after 3 of 10 steps at period 2.
        applyStimulus(15, 2);
        repeat (6) step_clk();
        checkOutput("abort pre position", position, 32'd8);
        checkOutput("abort pre busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        checkOutput("abort position", position, 32'd8);
        checkOutput("abort encabz", 32'(encabz), 32'(exp_abz(8)));
        checkOutput("abort done", 32'(done), 32'd1);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort cmd_ready", 32'(cmd_ready), 32'd0);
        step_clk();
        checkOutput("after abort cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("after abort done", 32'(done), 32'd0);
        checkOutput("after abort position", position, 32'd8);
        applyStimulus(9, 1);
        checkMove(8, 9, 1, 1, "post-abort");

        // Reset mid-move with the command source still asserting valid.
        cmd_target = 20;
        cmd_period = DIV_W'(1);
        cmd_valid  = 1'b1;
        step_clk();
        repeat (3) step_clk();
        checkOutput("mid-move position", position, 32'd12);
        checkOutput("mid-move cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        step_clk();
        checkOutput("mid reset position", position, 32'd0);
        checkOutput("mid reset encabz", 32'(encabz), 32'(exp_abz(0)));
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset done", 32'(done), 32'd0);
        checkOutput("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        step_clk();
        cmd_valid = 1'b0;
        checkMove(0, 20, 1, 20, "after reset");

        // Longest period: single step lands exactly at T+65535.
        applyStimulus(21, 65535);
        checkMove(20, 21, 65535, 1, "long period");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
